// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel word valid/ready handshake into the serializer
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] par_in;
    logic             par_valid;
    logic             par_ready;

    modport master (output par_in, output par_valid, input par_ready);
    modport slave  (input par_in, input par_valid, output par_ready);
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with one-word holding register
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    piso_serializer_if.slave     par,
    output logic                 serial_out,
    output logic                 load,
    output logic                 word_done,
    output logic                 busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              serial_out_q, serial_out_d;
    logic              load_q, load_d;
    logic              word_done_q, word_done_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              start;

    assign par.par_ready = ~hold_full_q & ~reset;
    assign accept        = par.par_valid & par.par_ready;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        start       = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) start = 1'b1;
            end
            SHIFT: begin
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = 4'(GAP_CYCLES - 1);
                    end else if (hold_full_q) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
            GAP: begin
                // The last gap cycle behaves like IDLE so the gap is exactly GAP_CYCLES long
                if (gap_cnt_q == 4'd0) begin
                    if (hold_full_q) start = 1'b1;
                    else             state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = SHIFT;
            bit_cnt_d   = '0;
        end

        // Accept and drain are exclusive: ready is low whenever hold can be drained
        if (accept) begin
            hold_d      = par.par_in;
            hold_full_d = 1'b1;
        end

        load_d       = (state_d == SHIFT);
        serial_out_d = load_d & (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
        word_done_d  = load_d & (bit_cnt_d == CW'(WIDTH - 1));
        busy_d       = (state_d != IDLE) | hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            serial_out_q <= 1'b0;
            load_q       <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            serial_out_q <= serial_out_d;
            load_q       <= load_d;
            word_done_q  <= word_done_d;
            busy_q       <= busy_d;
        end
    end

    assign serial_out = serial_out_q;
    assign load       = load_q;
    assign word_done  = word_done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - three serializer configurations checked against a word-level model
module tb_piso_serializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] pin [3];
    logic       pv  [3];
    logic       d_ser [3], d_load [3], d_done [3], d_busy [3], d_rdy [3];

    piso_serializer_if #(.WIDTH(8)) if_a ();
    piso_serializer_if #(.WIDTH(8)) if_b ();
    piso_serializer_if #(.WIDTH(8)) if_c ();

    assign if_a.par_in = pin[0]; assign if_a.par_valid = pv[0]; assign d_rdy[0] = if_a.par_ready;
    assign if_b.par_in = pin[1]; assign if_b.par_valid = pv[1]; assign d_rdy[1] = if_b.par_ready;
    assign if_c.par_in = pin[2]; assign if_c.par_valid = pv[2]; assign d_rdy[2] = if_c.par_ready;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .par(if_a.slave),
        .serial_out(d_ser[0]), .load(d_load[0]), .word_done(d_done[0]), .busy(d_busy[0]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .par(if_b.slave),
        .serial_out(d_ser[1]), .load(d_load[1]), .word_done(d_done[1]), .busy(d_busy[1]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .par(if_c.slave),
        .serial_out(d_ser[2]), .load(d_load[2]), .word_done(d_done[2]), .busy(d_busy[2]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word is a sequence of 8 bits in transmission order; m_pos is the index shown
    int         gap_p [3] = '{0, 2, 0};
    bit         msb_p [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] m_hold [3], m_word [3];
    bit         m_full [3];
    int         m_pos [3], m_gap [3];
    bit         started = 1'b0;

    function automatic bit tx_bit(input int d, input int k);
        logic [7:0] w;
        w = m_word[d];
        return msb_p[d] ? w[7-k] : w[k];
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_full[d] = 1'b0; m_pos[d] = -1; m_gap[d] = 0;
            end else begin
                bit acc, showing, ended, can_start;
                acc       = pv[d] && !m_full[d];
                showing   = m_pos[d] >= 0;
                ended     = showing && m_pos[d] == 7;
                can_start = (!showing && m_gap[d] <= 1) || (ended && gap_p[d] == 0);
                if (showing) begin
                    if (ended) begin m_pos[d] = -1; m_gap[d] = gap_p[d]; end
                    else m_pos[d]++;
                end else if (m_gap[d] > 0) m_gap[d]--;
                if (can_start && m_full[d]) begin
                    m_word[d] = m_hold[d]; m_pos[d] = 0; m_full[d] = 1'b0; m_gap[d] = 0;
                end
                if (acc) begin m_hold[d] = pin[d]; m_full[d] = 1'b1; end
            end
        end
    end

    // Observed stream capture and gap statistics
    logic [31:0] cap [3];
    int cap_n [3], done_n [3], zrun [3], gaps [3], last_gap [3];
    bit had [3];

    task automatic clear_obs();
        for (int d = 0; d < 3; d++) begin
            cap[d] = '0; cap_n[d] = 0; done_n[d] = 0; zrun[d] = 0; gaps[d] = 0;
            last_gap[d] = 0; had[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 3; d++) begin
                bit eload;
                eload = m_pos[d] >= 0;
                chk($sformatf("load[%0d]", d), int'(d_load[d]), int'(eload));
                chk($sformatf("serial_out[%0d]", d), int'(d_ser[d]), eload ? int'(tx_bit(d, m_pos[d])) : 0);
                chk($sformatf("word_done[%0d]", d), int'(d_done[d]), int'(m_pos[d] == 7));
                chk($sformatf("busy[%0d]", d), int'(d_busy[d]), int'(eload || m_gap[d] > 0 || m_full[d]));
                chk($sformatf("par_ready[%0d]", d), int'(d_rdy[d]), int'(!m_full[d] && !reset));
                if (d_load[d]) begin
                    cap[d] = {cap[d][30:0], d_ser[d]}; cap_n[d]++;
                    if (had[d] && zrun[d] > 0) begin gaps[d]++; last_gap[d] = zrun[d]; end
                    zrun[d] = 0; had[d] = 1'b1;
                end else if (had[d]) zrun[d]++;
                if (d_done[d]) done_n[d]++;
            end
        end
    end

    task automatic send(input int d, input logic [7:0] w);
        int n;
        n = 0;
        pin[d] = w; pv[d] = 1'b1;
        while (!d_rdy[d] && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        pv[d] = 1'b0; pin[d] = 8'h00;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (d_busy[d] && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("idle_timeout", 1, 0);
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin pin[d] = 8'h00; pv[d] = 1'b0; end
        clear_obs();
        repeat (3) @(posedge clk); #1;
        chk("reset_ready", int'(d_rdy[0]), 0);
        chk("reset_load", int'(d_load[0]), 0);
        chk("reset_busy", int'(d_busy[1]), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", int'(d_rdy[0]), 1);

        // Single word MSB first
        clear_obs();
        send(0, 8'hB5);
        wait_idle(0);
        chk("t1_bits", cap_n[0], 8);
        chk("t1_word", int'(cap[0][7:0]), 'hB5);
        chk("t1_done", done_n[0], 1);

        // Back-to-back words with no bubble
        clear_obs();
        send(0, 8'hB5);
        send(0, 8'h66);
        wait_idle(0);
        chk("t2_bits", cap_n[0], 16);
        chk("t2_stream", int'(cap[0][15:0]), 'hB566);
        chk("t2_gaps", gaps[0], 0);
        chk("t2_done", done_n[0], 2);

        // Two-cycle forced gap
        clear_obs();
        send(1, 8'h5A);
        send(1, 8'hC3);
        wait_idle(1);
        chk("t3_stream", int'(cap[1][15:0]), 'h5AC3);
        chk("t3_gap_count", gaps[1], 1);
        chk("t3_gap_len", last_gap[1], 2);

        // LSB first
        clear_obs();
        send(2, 8'h01);
        wait_idle(2);
        chk("t4_bits", cap_n[2], 8);
        chk("t4_stream", int'(cap[2][7:0]), 'h80);

        // Reset after the third bit with a word held
        clear_obs();
        send(0, 8'hFF);
        send(0, 8'hAA);
        @(posedge clk); #1;
        chk("t5_bits_before_reset", cap_n[0], 2);
        chk("t5_hold_full", int'(d_rdy[0]), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_load_in_reset", int'(d_load[0]), 0);
        chk("t5_ready_in_reset", int'(d_rdy[0]), 0);
        reset = 1'b0;
        clear_obs();
        #1;
        chk("t5_ready_release", int'(d_rdy[0]), 1);
        repeat (20) @(posedge clk); #1;
        chk("t5_no_tx", cap_n[0], 0);
        chk("t5_no_done", done_n[0], 0);

        // Valid while hold is full is not accepted
        clear_obs();
        send(0, 8'hA5);
        send(0, 8'h0F);
        chk("t6_ready_low", int'(d_rdy[0]), 0);
        pin[0] = 8'h3C; pv[0] = 1'b1;
        repeat (2) @(posedge clk); #1;
        pv[0] = 1'b0; pin[0] = 8'h00;
        wait_idle(0);
        chk("t6_bits", cap_n[0], 16);
        chk("t6_stream", int'(cap[0][15:0]), 'hA50F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
